niosii_ocimem_arbiter: RTL and testbench

Arbitrates a single-port on-chip debug RAM (OCI memory) between two requesters: the JTAG debug slave's system-clock command strobes and the CPU's debug-memory slave port. Sequences JTAG address-load, auto-incrementing read and write commands. Returns JTAG read data in a monitor data register with ready/error status. Sits in the CPU clock domain between the debug-slave sysclk logic and the OCI RAM.

---
 rtl/niosii_ocimem_arbiter_pkg.sv | 22 ++
 rtl/niosii_ocimem_arbiter_pick.sv | 56 +++++
 rtl/niosii_ocimem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_niosii_ocimem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/niosii_ocimem_arbiter_pkg.sv
// Shared types and default widths for the OCI memory arbiter.
package ocimem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_JTAG
    } owner_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } jop_t;

endpackage

// File: rtl/niosii_ocimem_arbiter_pick.sv
// Two-request grant picker for the OCI memory port.
// OCIMEM_ARB_RR_EN selects round-robin; otherwise JTAG has fixed priority.
module ocimem_arb_pick
    import ocimem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_en,
    input  logic   i_req_jtag,
    input  logic   i_req_cpu,
    output logic   o_gnt_jtag,
    output logic   o_gnt_cpu,
    output owner_t o_last_grant
);

    owner_t r_last_grant;

    // No grant is issued in RD_WAIT, so last_grant also names the owner of
    // the read in flight; the top uses it to route the returning data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= OWN_CPU;
        end else if (o_gnt_jtag) begin
            r_last_grant <= OWN_JTAG;
        end else if (o_gnt_cpu) begin
            r_last_grant <= OWN_CPU;
        end
    end

    assign o_last_grant = r_last_grant;

`ifdef OCIMEM_ARB_RR_EN
    always_comb begin
        o_gnt_jtag = 1'b0;
        o_gnt_cpu  = 1'b0;
        if (i_en) begin
            if (i_req_jtag && i_req_cpu) begin
                if (r_last_grant == OWN_JTAG) begin
                    o_gnt_cpu = 1'b1;
                end else begin
                    o_gnt_jtag = 1'b1;
                end
            end else begin
                o_gnt_jtag = i_req_jtag;
                o_gnt_cpu  = i_req_cpu;
            end
        end
    end
`else
    always_comb begin
        o_gnt_jtag = i_en & i_req_jtag;
        o_gnt_cpu  = i_en & i_req_cpu & ~i_req_jtag;
    end
`endif

endmodule

// File: rtl/niosii_ocimem_arbiter.sv
// Arbitrates the single-port OCI debug RAM between JTAG commands and the CPU
// debug slave. Optional round-robin via OCIMEM_ARB_RR_EN (see picker).
module niosii_ocimem_arbiter
    import ocimem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_load_addr,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic              jtag_rd,
    input  logic              jtag_wr,
    input  logic [DATA_W-1:0] jtag_wdata,
    input  logic              debugack,
    output logic [DATA_W-1:0] mon_rdata,
    output logic              mon_ready,
    output logic              mon_error,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_jptr;
    logic              r_jpend_vld;
    jop_t              r_jpend_op;
    logic [DATA_W-1:0] r_jpend_wdata;
    logic [DATA_W-1:0] r_mon_rdata;
    logic              r_mon_ready;
    logic              r_mon_error;
    logic [DATA_W-1:0] r_cpu_rdata;

    logic   w_creq;
    logic   w_grant_en;
    logic   w_gnt_jtag;
    logic   w_gnt_cpu;
    owner_t w_owner;
    logic   w_rd_jtag;
    logic   w_rd_cpu;
    logic   w_jdone;
    logic   w_cpu_done;
    logic   w_jstb;
    logic   w_jaccept;
    logic   w_jerror;

    assign w_creq     = cpu_read | cpu_write;
    assign w_grant_en = (r_state == IDLE) & ~reset;

    ocimem_arb_pick u_pick (
        .clk          (clk),
        .rst          (reset),
        .i_en         (w_grant_en),
        .i_req_jtag   (r_jpend_vld),
        .i_req_cpu    (w_creq),
        .o_gnt_jtag   (w_gnt_jtag),
        .o_gnt_cpu    (w_gnt_cpu),
        .o_last_grant (w_owner)
    );

    assign w_rd_jtag  = (r_state == RD_WAIT) & (w_owner == OWN_JTAG);
    assign w_rd_cpu   = (r_state == RD_WAIT) & (w_owner == OWN_CPU);
    assign w_jdone    = (w_gnt_jtag & (r_jpend_op == OP_WR)) | w_rd_jtag;
    assign w_cpu_done = (w_gnt_cpu & cpu_write) | w_rd_cpu;

    // A slot freed by this cycle's completion may take a new strobe.
    assign w_jstb    = jtag_rd | jtag_wr;
    assign w_jaccept = w_jstb & debugack & (~r_jpend_vld | w_jdone);
    assign w_jerror  = w_jstb & ~w_jaccept;

    always_comb begin
        w_state_nxt     = r_state;
        ram_en          = 1'b0;
        ram_we          = 1'b0;
        ram_addr        = cpu_address;
        ram_wdata       = cpu_writedata;
        cpu_waitrequest = w_creq & ~w_cpu_done;
        cpu_readdata    = r_cpu_rdata;
        case (r_state)
            IDLE: begin
                if (w_gnt_jtag) begin
                    ram_en    = 1'b1;
                    ram_we    = (r_jpend_op == OP_WR);
                    ram_addr  = r_jptr;
                    ram_wdata = r_jpend_wdata;
                    if (r_jpend_op == OP_RD) begin
                        w_state_nxt = RD_WAIT;
                    end
                end else if (w_gnt_cpu) begin
                    ram_en = 1'b1;
                    ram_we = cpu_write;
                    if (cpu_read) begin
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // RAM output is already registered; pass it through in the
                // acknowledge cycle and hold it afterwards.
                if (w_owner == OWN_CPU) begin
                    cpu_readdata = ram_rdata;
                end
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_jptr <= '0;
        end else if (jtag_load_addr) begin
            r_jptr <= jtag_addr;
        end else if (w_jdone) begin
            r_jptr <= r_jptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_jpend_vld   <= 1'b0;
            r_jpend_op    <= OP_RD;
            r_jpend_wdata <= '0;
            r_mon_ready   <= 1'b1;
        end else if (w_jaccept) begin
            r_jpend_vld   <= 1'b1;
            r_jpend_op    <= jtag_wr ? OP_WR : OP_RD;
            r_jpend_wdata <= jtag_wdata;
            r_mon_ready   <= 1'b0;
        end else if (w_jdone) begin
            r_jpend_vld <= 1'b0;
            r_mon_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mon_error <= 1'b0;
        end else if (w_jerror) begin
            r_mon_error <= 1'b1;
        end else if (jtag_load_addr) begin
            r_mon_error <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mon_rdata <= '0;
            r_cpu_rdata <= '0;
        end else begin
            if (w_rd_jtag) begin
                r_mon_rdata <= ram_rdata;
            end
            if (w_rd_cpu) begin
                r_cpu_rdata <= ram_rdata;
            end
        end
    end

    assign mon_rdata = r_mon_rdata;
    assign mon_ready = r_mon_ready;
    assign mon_error = r_mon_error;

endmodule

// File: tb/tb_niosii_ocimem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter and a behavioural RAM.
module tb_niosii_ocimem_arbiter;

    logic        clk;
    logic        reset;
    logic        jtag_load_addr;
    logic [7:0]  jtag_addr;
    logic        jtag_rd;
    logic        jtag_wr;
    logic [31:0] jtag_wdata;
    logic        debugack;
    logic [31:0] mon_rdata;
    logic        mon_ready;
    logic        mon_error;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    niosii_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .jtag_load_addr(jtag_load_addr), .jtag_addr(jtag_addr),
        .jtag_rd(jtag_rd), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
        .debugack(debugack),
        .mon_rdata(mon_rdata), .mon_ready(mon_ready), .mon_error(mon_error),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
        .cpu_waitrequest(cpu_waitrequest),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 32'h11) return 32'h1234_5678;
        if (i == 32'h20) return 32'hCAFE_0020;
        return {i[7:0], ~i[7:0], 16'hA5C3};
    endfunction

    // Behavioural single-port RAM, read data one cycle after enable.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata     <= ram[ram_addr];
        end
    end

    // Reference model: pointer, one pending JTAG command, one read in flight.
    logic [31:0] m_mem [256];
    logic [7:0]  m_ptr, m_baddr;
    logic        m_pv, m_pwr, m_busy, m_busj, m_ready, m_err;
    logic [31:0] m_pdata, m_rdata, m_chold;
    logic        e_gj, e_gc, e_en, e_we, e_wait;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata, e_crd;
    logic        last_wait = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = '0; m_pv = 1'b0; m_pwr = 1'b0; m_pdata = '0;
        m_rdata = '0; m_ready = 1'b1; m_err = 1'b0;
        m_busy = 1'b0; m_busj = 1'b0; m_baddr = '0; m_chold = '0;
    endtask

    task automatic model_comb();
        logic cdone;
        e_gj = 1'b0;
        e_gc = 1'b0;
        if (!reset && !m_busy) begin
            if (m_pv) e_gj = 1'b1;
            else if (cpu_read || cpu_write) e_gc = 1'b1;
        end
        e_en    = e_gj | e_gc;
        e_we    = e_gj ? m_pwr : (e_gc & cpu_write);
        e_addr  = e_gj ? m_ptr : cpu_address;
        e_wdata = e_gj ? m_pdata : cpu_writedata;
        cdone   = (e_gc && cpu_write) || (m_busy && !m_busj);
        e_wait  = (cpu_read || cpu_write) && !cdone;
        e_crd   = (m_busy && !m_busj) ? m_mem[m_baddr] : m_chold;
    endtask

    task automatic model_step();
        logic jdone;
        if (reset) begin
            model_reset();
            return;
        end
        jdone = (e_gj && m_pwr) || (m_busy && m_busj);
        if (m_busy) begin
            if (m_busj) m_rdata = m_mem[m_baddr];
            else        m_chold = m_mem[m_baddr];
            m_busy = 1'b0;
        end else if (e_en) begin
            if (e_we) m_mem[e_addr] = e_wdata;
            else begin
                m_busy = 1'b1; m_busj = e_gj; m_baddr = e_addr;
            end
        end
        if (jtag_load_addr) m_ptr = jtag_addr;
        else if (jdone)     m_ptr = m_ptr + 8'd1;
        if (jdone) begin
            m_pv = 1'b0; m_ready = 1'b1;
        end
        if (jtag_rd || jtag_wr) begin
            if (!debugack || m_pv) m_err = 1'b1;
            else begin
                m_pv = 1'b1; m_pwr = jtag_wr; m_pdata = jtag_wdata; m_ready = 1'b0;
            end
        end else if (jtag_load_addr) begin
            m_err = 1'b0;
        end
    endtask

    task automatic compare();
        model_comb();
        chk("ram_en", ram_en, e_en);
        if (e_en) begin
            chk("ram_we", ram_we, e_we);
            chk("ram_addr", ram_addr, e_addr);
            if (e_we) chk("ram_wdata", ram_wdata, e_wdata);
        end
        chk("cpu_waitrequest", cpu_waitrequest, e_wait);
        chk("cpu_readdata", cpu_readdata, e_crd);
        chk("mon_rdata", mon_rdata, m_rdata);
        chk("mon_ready", mon_ready, m_ready);
        chk("mon_error", mon_error, m_err);
        last_wait = e_wait;
    endtask

    // Inputs are set just after a posedge; check mid-cycle, advance the model.
    task automatic tick();
        @(negedge clk);
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic jclear();
        jtag_load_addr = 1'b0; jtag_rd = 1'b0; jtag_wr = 1'b0;
    endtask

    initial begin
        int unsigned cnt;
        logic        got_ack;
        reset = 1'b1; debugack = 1'b1;
        jclear(); jtag_addr = '0; jtag_wdata = '0;
        cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0;
        for (int unsigned i = 0; i < 256; i++) begin
            ram[i]   <= init_word(i);
            m_mem[i]  = init_word(i);
        end
        model_reset();
        @(posedge clk); #1;
        chk("rst mon_ready", mon_ready, 1);
        chk("rst mon_rdata", mon_rdata, 0);
        chk("rst ram_en", ram_en, 0);
        tick(); tick();
        reset = 1'b0;

        // JTAG write at 0x10
        jtag_load_addr = 1'b1; jtag_addr = 8'h10; tick(); jclear();
        jtag_wr = 1'b1; jtag_wdata = 32'hDEAD_BEEF; tick(); jclear();
        #1;
        chk("jwr ram_we", ram_we, 1);
        chk("jwr ram_addr", ram_addr, 32'h10);
        chk("jwr ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("jwr busy", mon_ready, 0);
        tick();
        chk("jwr ready", mon_ready, 1);

        // JTAG read at 0x11: result three cycles after strobe
        jtag_rd = 1'b1; tick(); jclear();
        #1; chk("jrd ram_addr", ram_addr, 32'h11);
        tick(); tick();
        chk("jrd mon_rdata", mon_rdata, 32'h1234_5678);
        chk("jrd ready", mon_ready, 1);

        // Pointer wrap
        jtag_load_addr = 1'b1; jtag_addr = 8'hFF; tick(); jclear();
        jtag_rd = 1'b1; tick(); jclear();
        #1; chk("wrap addr FF", ram_addr, 32'hFF);
        tick(); tick();
        jtag_rd = 1'b1; tick(); jclear();
        #1; chk("wrap addr 00", ram_addr, 32'h00);
        tick(); tick();

        // Errors
        debugack = 1'b0; jtag_wr = 1'b1; jtag_wdata = 32'h0BAD_0BAD; tick(); jclear();
        debugack = 1'b1;
        #1;
        chk("noack error", mon_error, 1);
        chk("noack ram_en", ram_en, 0);
        chk("noack ready", mon_ready, 1);
        tick();
        jtag_rd = 1'b1; tick();
        tick(); jclear();
        #1; chk("dup error", mon_error, 1);
        tick();
        chk("dup first done", mon_ready, 1);
        chk("dup first data", mon_rdata, init_word(1));
        jtag_load_addr = 1'b1; jtag_addr = 8'h30; tick(); jclear();
        chk("load clears error", mon_error, 0);

        // Contention: JTAG read pending, CPU read at 0x20 waits two extra cycles
        jtag_rd = 1'b1; tick(); jclear();
        cpu_read = 1'b1; cpu_address = 8'h20;
        cnt = 0; got_ack = 1'b0;
        for (int unsigned k = 0; k < 10 && !got_ack; k++) begin
            #1;
            if (!cpu_waitrequest) begin
                got_ack = 1'b1;
                chk("contend cpu data", cpu_readdata, 32'hCAFE_0020);
            end else begin
                cnt++;
            end
            tick();
        end
        chk("contend ack seen", got_ack, 1);
        chk("contend wait cycles", cnt, 3);
        cpu_read = 1'b0;
        tick();

        // Async reset during a CPU RD_WAIT
        cpu_read = 1'b1; cpu_address = 8'h42; tick();
        #1; reset = 1'b1; #1;
        chk("arst ram_en", ram_en, 0);
        chk("arst cpu_readdata", cpu_readdata, 0);
        chk("arst waitrequest", cpu_waitrequest, 1);
        chk("arst mon_ready", mon_ready, 1);
        chk("arst mon_rdata", mon_rdata, 0);
        model_reset();
        tick();
        reset = 1'b0;
        #1; chk("post-rst readdata", cpu_readdata, 0);
        cnt = 0;
        while (cpu_waitrequest && cnt < 10) begin
            tick(); cnt++;
        end
        chk("post-rst fresh data", cpu_readdata, init_word(32'h42));
        tick();
        cpu_read = 1'b0;
        tick();

        // Randomized traffic
        for (int unsigned c = 0; c < 3000; c++) begin
            int unsigned j;
            int unsigned r;
            jclear();
            j = $urandom_range(0, 99);
            if (j < 8) begin
                jtag_load_addr = 1'b1; jtag_addr = 8'($urandom);
            end else if (j < 22) begin
                jtag_rd = 1'b1;
            end else if (j < 36) begin
                jtag_wr = 1'b1; jtag_wdata = $urandom;
            end
            debugack = ($urandom_range(0, 19) != 0);
            if (!last_wait) begin
                r = $urandom_range(0, 9);
                cpu_read      = (r < 3);
                cpu_write     = (r >= 3 && r < 6);
                cpu_address   = 8'($urandom);
                cpu_writedata = $urandom;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
